trdb_packet_arbiter: RTL and testbench
======================================

// Module: trdb_packet_arbiter
//
// PURPOSE
//  Round-robin arbiter that shares one trdb_stream_align instance among
//  NUM_SRC trace packet sources (one per traced core).
//  Picks a source and locks onto it until the aligner grants the whole packet.
//  Passes that packet and its source id to the aligner, then returns the grant
//  to the owning source. Sits between the per-core packet FIFOs and the
//  aligner.
//
// PARAMETERS
//  NUM_SRC  4  number of packet sources; legal range 2..16.
//  SRC_W    $clog2(NUM_SRC)  source id width; derived, not overridable.
//
// PORTS
//  clk_i              in   1                          clock; all logic on posedge.
//  rst_ni             in   1                          reset; synchronous, active-low.
//  src_packet_bits_i  in   NUM_SRC x PACKET_LEN        packet payload per source.
//  src_packet_len_i   in   NUM_SRC x PACKET_HEADER_LEN packet length per source.
//  src_valid_i        in   NUM_SRC                    source has a packet pending.
//  src_grant_o        out  NUM_SRC                    packet consumed; one-hot or zero.
//  packet_bits_o      out  PACKET_LEN                 to aligner packet_bits_i.
//  packet_len_o       out  PACKET_HEADER_LEN          to aligner packet_len_i.
//  valid_o            out  1                          to aligner valid_i.
//  grant_i            in   1                          from aligner grant_o.
//  src_id_o           out  SRC_W                      id of the locked source.
//  proto_err_o        out  1                          sticky: locked source dropped valid.
//
// BEHAVIOUR
//  Reset (rst_ni==0 at posedge):
//   - state=IDLE, sel_q=0, rr_ptr_q=0, proto_err_o=0.
//   - All outputs are 0 in IDLE.
//  State machine:
//   IDLE
//    - valid_o=0, src_grant_o=0.
//    - If any src_valid_i: sel_q <= first set index searching from rr_ptr_q
//      upward, with wrap modulo NUM_SRC.
//    - Then state <= LOCKED.
//   LOCKED
//    - packet_bits_o, packet_len_o and src_id_o = sel_q, muxed combinationally
//      from sel_q.
//    - valid_o = src_valid_i[sel_q].
//    - If valid_o && grant_i:
//      - src_grant_o[sel_q]=1 in the same cycle (combinational path, no
//        register).
//      - rr_ptr_q <= (sel_q==NUM_SRC-1) ? 0 : sel_q+1.
//      - state <= IDLE.
//    - If !src_valid_i[sel_q] (protocol violation):
//      - proto_err_o <= 1.
//      - state <= IDLE; rr_ptr_q is unchanged.
//  Latency and throughput:
//   - Request to valid_o is 1 cycle.
//   - One IDLE bubble after each packet. Accepted, because the aligner emits
//     at least one word per packet.
//  Handshake rules:
//   - Sources hold bits, len and valid stable from assertion until their grant.
//   - The arbiter never switches source while LOCKED.
//   - grant_i is ignored when valid_o==0.
//   - src_grant_o is never asserted for an unlocked source.
//  Fairness:
//   - Each source waits at most NUM_SRC-1 packets once it asserts valid.
//   - rr_ptr_q advances only on a completed grant.
//  Boundary conditions:
//   - Single requester: it is re-selected after each bubble.
//   - All requesters set: served in order rr_ptr_q, rr_ptr_q+1, ...
//   - New src_valid_i in the same cycle as a grant: considered in the next IDLE.
//   - Reset while LOCKED: returns to IDLE with no src_grant_o pulse. A
//     partially sent packet is abandoned; the aligner is reset alongside.
//   - proto_err_o clears only on reset.
//
// TESTING
//  1. Reset then idle: all src_valid_i=0 for 10 cycles -> valid_o=0,
//     src_grant_o=0, state stays IDLE.
//  2. Single source: src_valid_i=4'b0100, len=20, aligner grants after 2 cycles
//     -> src_id_o=2, valid_o high 1 cycle after the request, src_grant_o=4'b0100
//     pulses once, rr_ptr_q=3.
//  3. All valid (4'b1111), grant every cycle -> grant order 0,1,2,3,0, each
//     separated by one IDLE cycle.
//  4. Hold-off: lock src 1 with grant_i=0 for 8 cycles while src 0 and src 3 are
//     valid -> src_id_o stays 1, no other src_grant_o.
//  5. Protocol violation: locked src 2 drops valid before grant ->
//     proto_err_o=1 next cycle, IDLE, rr_ptr_q unchanged; a later reset clears
//     proto_err_o.
//  6. Reset mid-LOCKED: assert rst_ni=0 for one posedge while src 3 is locked ->
//     no src_grant_o pulse, sel_q=0, rr_ptr_q=0, next selection starts from
//     src 0.

Source files
------------

// File: rtl/trdb_packet_arbiter_if.sv
// Bundle of the arbiter's handshake and data signals. The upstream side
// (per-core packet FIFOs plus the aligner's grant) drives the master
// modport. The arbiter itself connects through the slave modport.
//
// Signals:
//   src_packet_bits_i  NUM_SRC x PACKET_LEN         payload per source
//   src_packet_len_i   NUM_SRC x PACKET_HEADER_LEN  length per source
//   src_valid_i        NUM_SRC                      source has a packet pending
//   src_grant_o        NUM_SRC                      packet consumed (one-hot/zero)
//   packet_bits_o      PACKET_LEN                   to aligner packet_bits_i
//   packet_len_o       PACKET_HEADER_LEN            to aligner packet_len_i
//   valid_o            1                            to aligner valid_i
//   grant_i            1                            from aligner grant_o
//   src_id_o           SRC_W                        id of the locked source
//   proto_err_o        1                            sticky protocol error
interface trdb_packet_arbiter_if #(
  parameter int NUM_SRC           = 4,
  parameter int PACKET_LEN        = 64,
  parameter int PACKET_HEADER_LEN = 7
);
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0][PACKET_LEN-1:0]        src_packet_bits_i;
  logic [NUM_SRC-1:0][PACKET_HEADER_LEN-1:0] src_packet_len_i;
  logic [NUM_SRC-1:0]                        src_valid_i;
  logic [NUM_SRC-1:0]                        src_grant_o;
  logic [PACKET_LEN-1:0]                     packet_bits_o;
  logic [PACKET_HEADER_LEN-1:0]              packet_len_o;
  logic                                      valid_o;
  logic                                      grant_i;
  logic [SRC_W-1:0]                          src_id_o;
  logic                                      proto_err_o;

  modport master (
    output src_packet_bits_i, src_packet_len_i, src_valid_i, grant_i,
    input  src_grant_o, packet_bits_o, packet_len_o, valid_o, src_id_o,
           proto_err_o
  );

  modport slave (
    input  src_packet_bits_i, src_packet_len_i, src_valid_i, grant_i,
    output src_grant_o, packet_bits_o, packet_len_o, valid_o, src_id_o,
           proto_err_o
  );
endinterface

// File: rtl/trdb_packet_arbiter.sv
// Round-robin arbiter that shares one trdb_stream_align instance among
// NUM_SRC trace packet sources. In IDLE it picks the first pending source at
// or after the round-robin pointer. It then locks onto that source until the
// aligner grants the packet. The grant is forwarded combinationally to the
// owning source. One IDLE bubble follows every packet.
//
// Ports:
//   clk_i   clock, all logic on the rising edge
//   rst_ni  synchronous active-low reset
//   bus     trdb_packet_arbiter_if.slave; source-side and aligner-side signals
//
// NUM_SRC must lie in the range 2..16.
module trdb_packet_arbiter #(
  parameter int NUM_SRC           = 4,
  parameter int PACKET_LEN        = 64,
  parameter int PACKET_HEADER_LEN = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  trdb_packet_arbiter_if.slave  bus
);
  localparam int SRC_W = $clog2(NUM_SRC);
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRC - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [SRC_W-1:0] sel_q, sel_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             proto_err_q, proto_err_d;

  logic [SRC_W-1:0] rr_pick;
  logic             rr_hit;
  int               rr_idx;
  logic [SRC_W-1:0] rr_idx_w;

  // Scan offsets from high to low. The last hit wins, so the result is the
  // source with the smallest offset from rr_ptr_q. This is the first pending
  // source found when searching upward with wrap.
  always_comb begin : rr_search
    rr_pick  = rr_ptr_q;
    rr_hit   = 1'b0;
    rr_idx   = 0;
    rr_idx_w = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      rr_idx = int'(rr_ptr_q) + k;
      if (rr_idx >= NUM_SRC) begin
        rr_idx = rr_idx - NUM_SRC;
      end
      rr_idx_w = SRC_W'(rr_idx);
      if (bus.src_valid_i[rr_idx_w]) begin
        rr_pick = rr_idx_w;
        rr_hit  = 1'b1;
      end
    end
  end

  always_comb begin : fsm_next
    state_d           = state_q;
    sel_d             = sel_q;
    rr_ptr_d          = rr_ptr_q;
    proto_err_d       = proto_err_q;
    bus.valid_o       = 1'b0;
    bus.src_grant_o   = '0;
    bus.packet_bits_o = '0;
    bus.packet_len_o  = '0;
    bus.src_id_o      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (rr_hit) begin
          sel_d   = rr_pick;
          state_d = ST_LOCKED;
        end
      end

      ST_LOCKED: begin
        bus.packet_bits_o = bus.src_packet_bits_i[sel_q];
        bus.packet_len_o  = bus.src_packet_len_i[sel_q];
        bus.src_id_o      = sel_q;
        bus.valid_o       = bus.src_valid_i[sel_q];
        if (!bus.src_valid_i[sel_q]) begin
          // The locked source withdrew its packet before the grant.
          // Drop the lock and keep rr_ptr_q unchanged.
          proto_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (bus.grant_i) begin
          // A reset that coincides with the aligner's grant abandons the
          // packet. Suppress the grant so the source does not discard it.
          bus.src_grant_o[sel_q] = rst_ni;
          rr_ptr_d = (sel_q == LAST_SRC) ? '0 : sel_q + 1'b1;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.proto_err_o = proto_err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      proto_err_q <= proto_err_d;
    end
  end
endmodule

// File: tb/tb_trdb_packet_arbiter.sv
// Self-checking bench for trdb_packet_arbiter. A cycle-level behavioural model
// predicts every output in every cycle. On top of that, each directed scenario
// checks the observed grant order against a fixed list, and every grant is
// checked for round-robin fairness.
module tb_trdb_packet_arbiter;
  localparam int NUM_SRC           = 4;
  localparam int PACKET_LEN        = 32;
  localparam int PACKET_HEADER_LEN = 6;
  localparam int SRC_W             = $clog2(NUM_SRC);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  trdb_packet_arbiter_if #(
    .NUM_SRC(NUM_SRC), .PACKET_LEN(PACKET_LEN), .PACKET_HEADER_LEN(PACKET_HEADER_LEN)
  ) bus ();

  trdb_packet_arbiter #(
    .NUM_SRC(NUM_SRC), .PACKET_LEN(PACKET_LEN), .PACKET_HEADER_LEN(PACKET_HEADER_LEN)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state.
  bit m_busy;
  int m_owner;
  int m_ptr;
  bit m_err;
  int wait_cnt [NUM_SRC];
  int refill_pct;
  int arrival_pct;
  int gnt_log[$];
  int exp_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [NUM_SRC-1:0] req);
    for (int k = 0; k < NUM_SRC; k++) begin
      if (req[(ptr + k) % NUM_SRC]) return (ptr + k) % NUM_SRC;
    end
    return -1;
  endfunction

  task automatic load_src(input int s, input bit vld, input logic [PACKET_HEADER_LEN-1:0] len);
    bus.src_valid_i[SRC_W'(s)]       = vld;
    bus.src_packet_bits_i[SRC_W'(s)] = PACKET_LEN'($urandom);
    bus.src_packet_len_i[SRC_W'(s)]  = len;
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_err   = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) wait_cnt[s] = 0;
  endtask

  task automatic clear_sources();
    for (int s = 0; s < NUM_SRC; s++) load_src(s, 1'b0, '0);
  endtask

  // One clock cycle: compare outputs mid-cycle, advance the model at the edge,
  // then let the sources react to what was consumed.
  task automatic step(input logic gnt_in);
    logic [NUM_SRC-1:0]           e_gnt;
    logic                         e_vld;
    int                           e_id;
    logic [PACKET_LEN-1:0]        e_bits;
    logic [PACKET_HEADER_LEN-1:0] e_len;
    bit                           fired;
    int                           o;
    bus.grant_i = gnt_in;
    @(negedge clk);
    e_gnt  = '0;
    e_vld  = 1'b0;
    e_id   = 0;
    e_bits = '0;
    e_len  = '0;
    if (m_busy) begin
      e_vld  = bus.src_valid_i[SRC_W'(m_owner)];
      e_id   = m_owner;
      e_bits = bus.src_packet_bits_i[SRC_W'(m_owner)];
      e_len  = bus.src_packet_len_i[SRC_W'(m_owner)];
      if (e_vld && gnt_in && rst_n) e_gnt[SRC_W'(m_owner)] = 1'b1;
    end
    check("valid_o", bus.valid_o, e_vld);
    check("src_grant_o", bus.src_grant_o, e_gnt);
    check("src_id_o", bus.src_id_o, e_id);
    check("packet_bits_o", bus.packet_bits_o, e_bits);
    check("packet_len_o", bus.packet_len_o, e_len);
    check("proto_err_o", bus.proto_err_o, m_err);
    for (int s = 0; s < NUM_SRC; s++) begin
      if (bus.src_grant_o[SRC_W'(s)] === 1'b1) gnt_log.push_back(s);
    end

    @(posedge clk);
    fired = (e_gnt != '0);
    o     = m_owner;
    if (!rst_n) begin
      model_reset();
    end else if (!m_busy) begin
      if (bus.src_valid_i != '0) begin
        m_owner = rr_pick(m_ptr, bus.src_valid_i);
        m_busy  = 1'b1;
      end
    end else if (!bus.src_valid_i[SRC_W'(m_owner)]) begin
      m_err  = 1'b1;
      m_busy = 1'b0;
      wait_cnt[m_owner] = 0;
    end else if (gnt_in) begin
      check("fairness", wait_cnt[m_owner] <= NUM_SRC - 1, 1);
      wait_cnt[m_owner] = 0;
      for (int s = 0; s < NUM_SRC; s++) begin
        if (s != m_owner && bus.src_valid_i[SRC_W'(s)]) wait_cnt[s]++;
      end
      m_ptr  = (m_owner + 1) % NUM_SRC;
      m_busy = 1'b0;
    end
    #1;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (fired && s == o) begin
        load_src(s, $urandom_range(0, 99) < refill_pct, PACKET_HEADER_LEN'($urandom));
      end else if (!bus.src_valid_i[SRC_W'(s)] && $urandom_range(0, 99) < arrival_pct) begin
        load_src(s, 1'b1, PACKET_HEADER_LEN'($urandom));
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0);
    rst_n = 1'b1;
  endtask

  task automatic check_order(input string tag);
    check({tag, "_count"}, gnt_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < gnt_log.size(); i++) begin
      check($sformatf("%s_%0d", tag, i), gnt_log[i], exp_log[i]);
    end
    gnt_log.delete();
  endtask

  initial begin
    rst_n       = 1'b0;
    refill_pct  = 0;
    arrival_pct = 0;
    bus.grant_i = 1'b0;
    clear_sources();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    gnt_log.delete();

    // Idle after reset; a stray aligner grant must be ignored.
    for (int i = 0; i < 10; i++) step(1'b1);
    exp_log = {};
    check_order("t1_idle");

    // Single source 2, granted after two locked cycles; pointer moves to 3.
    do_reset();
    load_src(2, 1'b1, 6'd20);
    step(1'b0);
    step(1'b0);
    check("t2_valid_after_req", bus.valid_o, 1'b1);
    check("t2_src_id", bus.src_id_o, 2);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    load_src(0, 1'b1, 6'd3);
    load_src(3, 1'b1, 6'd4);
    step(1'b1);
    step(1'b1);
    exp_log = {2, 3};
    check_order("t2_order");

    // All sources pending and refilling, aligner always grants.
    do_reset();
    clear_sources();
    refill_pct = 100;
    for (int s = 0; s < NUM_SRC; s++) load_src(s, 1'b1, PACKET_HEADER_LEN'($urandom));
    for (int i = 0; i < 10; i++) step(1'b1);
    exp_log = {0, 1, 2, 3, 0};
    check_order("t3_order");

    // Hold-off: source 1 stays locked while others wait.
    refill_pct = 0;
    do_reset();
    clear_sources();
    load_src(1, 1'b1, 6'd9);
    step(1'b0);
    load_src(0, 1'b1, 6'd5);
    load_src(3, 1'b1, 6'd6);
    for (int i = 0; i < 8; i++) step(1'b0);
    check("t4_src_id_held", bus.src_id_o, 1);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    exp_log = {1, 3};
    check_order("t4_order");

    // Protocol violation: locked source 2 withdraws before its grant.
    do_reset();
    clear_sources();
    load_src(2, 1'b1, 6'd7);
    step(1'b0);
    step(1'b0);
    bus.src_valid_i[2] = 1'b0;
    step(1'b1);
    check("t5_err_set", bus.proto_err_o, 1'b1);
    for (int s = 0; s < NUM_SRC; s++) load_src(s, 1'b1, PACKET_HEADER_LEN'($urandom));
    step(1'b1);
    step(1'b1);
    exp_log = {0};
    check_order("t5_ptr_kept");
    check("t5_err_sticky", bus.proto_err_o, 1'b1);
    clear_sources();
    do_reset();
    step(1'b0);
    check("t5_err_cleared", bus.proto_err_o, 1'b0);

    // Reset while source 3 is locked and the aligner grants.
    do_reset();
    load_src(3, 1'b1, 6'd11);
    step(1'b0);
    step(1'b0);
    rst_n = 1'b0;
    step(1'b1);
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) load_src(s, 1'b1, PACKET_HEADER_LEN'($urandom));
    step(1'b1);
    step(1'b1);
    exp_log = {0};
    check_order("t6_after_reset");

    // Randomised traffic with compliant sources.
    do_reset();
    clear_sources();
    refill_pct  = 40;
    arrival_pct = 30;
    for (int i = 0; i < 400; i++) step(1'(($urandom_range(0, 99) < 50) ? 1 : 0));
    gnt_log.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
